// File: rtl/alu_seq_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_exec
//  Description : Multi-cycle ALU execution unit for the 16-bit RISC datapath.
//                AND/OR/ADD/NOR/SUB/SLT finish in one cycle. SLL/SRL run on a
//                serial shifter that moves one bit position per cycle.
//                Requests arrive over a valid/ready handshake, and results
//                leave over a second valid/ready handshake.
//  Ports       : clk          - system clock, rising edge
//                reset        - synchronous active-high reset
//                in_valid     - request valid
//                in_ready     - unit idle and able to accept a request
//                alucontrol   - 3-bit operation code
//                a, b         - operands (b[S-1:0] is the shift amount)
//                out_valid    - result valid
//                out_ready    - consumer accepts result
//                result, zero - registered result and (result == 0) flag
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_exec #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   alucontrol,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero
);

    localparam int c_SHW = $clog2(N);
    localparam logic [c_SHW-1:0] c_CNT_ZERO = '0;
    localparam logic [c_SHW-1:0] c_CNT_ONE  = {{(c_SHW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [N-1:0]       r_shreg;
    logic [c_SHW-1:0]   r_cnt;
    logic               r_dir_right;
    logic [N-1:0]       r_result;
    logic               r_zero;

    logic [N-1:0]       w_alu_res;
    logic [N-1:0]       w_shift_next;
    logic [c_SHW-1:0]   w_k;
    logic               w_is_shift;
    logic               w_start_shift;
    logic               w_accept;
    logic               w_ready;

    // Reset is gated in so that a request presented alongside reset is
    // never accepted and in_ready reads low throughout reset.
    assign w_ready       = (r_state == S_IDLE) && !reset;
    assign w_accept      = in_valid && w_ready;
    assign w_k           = b[c_SHW-1:0];
    assign w_is_shift    = (alucontrol[2:1] == 2'b11);
    assign w_start_shift = w_is_shift && (w_k != c_CNT_ZERO);

    // Single-cycle operations. For shifts this path only serves k == 0,
    // where the result is simply a.
    always_comb begin
        w_alu_res = '0;
        case (alucontrol)
            3'b000:  w_alu_res = a & b;
            3'b001:  w_alu_res = a | b;
            3'b010:  w_alu_res = a + b;
            3'b011:  w_alu_res = ~(a | b);
            3'b100:  w_alu_res = a - b;
            3'b101:  w_alu_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            default: w_alu_res = a;
        endcase
    end

    assign w_shift_next = r_dir_right ? {1'b0, r_shreg[N-1:1]}
                                      : {r_shreg[N-2:0], 1'b0};

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_start_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_dir_right <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_start_shift) begin
                            r_shreg     <= a;
                            r_cnt       <= w_k;
                            r_dir_right <= alucontrol[0];
                        end else begin
                            r_result <= w_alu_res;
                            r_zero   <= (w_alu_res == '0);
                        end
                    end
                end
                S_SHIFT: begin
                    r_shreg <= w_shift_next;
                    r_cnt   <= r_cnt - c_CNT_ONE;
                    // Last shift step: publish the final value directly.
                    if (r_cnt == c_CNT_ONE) begin
                        r_result <= w_shift_next;
                        r_zero   <= (w_shift_next == '0);
                    end
                end
                default: begin
                    // DONE holds result/zero stable under backpressure.
                end
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_exec
//  Description : Self-checking bench for alu_seq_exec. Directed vectors plus
//                randomized operations compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alucontrol;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_exec #(.N(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero)
    );

    // Behavioural reference: plain arithmetic on integers.
    function automatic logic [15:0] model(input logic [2:0] op,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        int sx, sy, k;
        sx = (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
        sy = (y >= 16'h8000) ? int'(y) - 65536 : int'(y);
        k  = int'(y) % 16;
        case (op)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return 16'((int'(x) + int'(y)) % 65536);
            3'd3:    return ~(x | y);
            3'd4:    return 16'((int'(x) - int'(y) + 65536) % 65536);
            3'd5:    return (sx < sy) ? 16'd1 : 16'd0;
            3'd6:    return 16'((int'(x) * (1 << k)) % 65536);
            default: return 16'(int'(x) / (1 << k));
        endcase
    endfunction

    // Issue one operation from a negedge, check latency/result, hold the
    // result for 'hold' cycles of backpressure (with ignored requests), then
    // complete the output handshake. Ends on a negedge.
    task automatic do_op(input logic [2:0] op, input logic [15:0] ta,
                         input logic [15:0] tb_v, input int hold,
                         input string name);
        logic [15:0] exp;
        int          lat;
        int          cyc;
        exp = model(op, ta, tb_v);
        lat = (op >= 3'd6 && (int'(tb_v) % 16) != 0) ? (int'(tb_v) % 16) + 1 : 1;

        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready got %b exp 1", name, in_ready);
        end
        alucontrol = op; a = ta; b = tb_v; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); alucontrol = 3'($urandom);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_ready got %b exp 0", name, in_ready);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != lat) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", name, cyc, lat);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result got %h exp %h", name, result, exp);
        end
        checks++;
        if (zero !== (exp == 16'h0000)) begin
            errors++;
            $display("FAIL %s zero got %b exp %b", name, zero, (exp == 16'h0000));
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done_ready got %b exp 0", name, in_ready);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom); alucontrol = 3'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold v/r/rdy got %b/%h/%b exp 1/%h/0",
                         name, out_valid, result, in_ready, exp);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release v/rdy got %b/%b exp 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; out_ready = 1'b0;
        // A request asserted during reset must be discarded.
        in_valid = 1'b1; alucontrol = 3'd2; a = 16'h0005; b = 16'h0005;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rdy/v/res/z got %b/%b/%h/%b exp 0/0/0000/0",
                     in_ready, out_valid, result, zero);
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept out_valid got %b exp 0", out_valid);
        end
    endtask

    task automatic test_directed;
        do_op(3'd2, 16'h7FFF, 16'h0001, 0, "add_wrap");
        do_op(3'd4, 16'h1234, 16'h1234, 0, "sub_zero");
        do_op(3'd3, 16'h00FF, 16'h0F00, 0, "nor");
        do_op(3'd0, 16'hF0F0, 16'h3C3C, 0, "and");
        do_op(3'd1, 16'hF000, 16'h000F, 0, "or");
        do_op(3'd5, 16'h8000, 16'h0001, 0, "slt_neg");
        do_op(3'd5, 16'h0001, 16'h8000, 0, "slt_pos");
        do_op(3'd5, 16'h7FFF, 16'h8000, 0, "slt_ovf");
        do_op(3'd6, 16'h0003, 16'h0004, 0, "sll4");
        do_op(3'd7, 16'h8000, 16'h000F, 0, "srl15");
        do_op(3'd6, 16'h8000, 16'h0010, 0, "sll_k0");
        do_op(3'd7, 16'hABCD, 16'hFFF1, 0, "srl_upper_ign");
    endtask

    task automatic test_backpressure;
        do_op(3'd2, 16'h0001, 16'h0001, 5, "backpressure");
    endtask

    task automatic test_reset_mid_shift;
        do_op(3'd2, 16'h0001, 16'h0001, 0, "pre_reset_add");
        alucontrol = 3'd6; a = 16'h0001; b = 16'h0008; in_valid = 1'b1;
        @(posedge clk);                 // accept
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);                 // shift 1
        @(negedge clk);
        @(posedge clk);                 // shift 2
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);                 // reset on 3rd shift edge
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== 16'h0 || zero !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_shift_reset v/res/z/rdy got %b/%h/%b/%b exp 0/0000/0/0",
                     out_valid, result, zero, in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_shift_release_ready got %b exp 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_shift_discard out_valid got %b exp 0", out_valid);
        end
        do_op(3'd0, 16'hFFFF, 16'h0F0F, 0, "post_reset_and");
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [15:0] ra;
        logic [15:0] rb;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            do_op(op, ra, rb, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alucontrol = 3'd0; a = 16'h0; b = 16'h0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_shift;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
